// File: rtl/fir_host_ctrl_if.sv
// AXI-Lite + AXI-Stream bundle between the host controller (master) and the FIR accelerator (slave).
// Wires only: no latency, and backpressure is carried by the ready/valid pairs themselves.
interface fir_host_ctrl_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
               ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output awready, wready, arready, rvalid, rdata,
               ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_host_ctrl.sv
// Bring-up driver for the FIR: programs length/taps, starts, streams samples in, captures results, polls ap_done.
// Results appear on res_* one cycle after each sm handshake; every channel waits on its slave's ready/valid.
module fir_host_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int POLL_GAP    = 4
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            data_len,
    output logic [3:0]             tap_idx,
    input  logic [pDATA_WIDTH-1:0] tap_val,
    output logic [31:0]            x_idx,
    input  logic [pDATA_WIDTH-1:0] x_val,
    fir_host_ctrl_if.master        bus,
    output logic                   res_valid,
    output logic [pDATA_WIDTH-1:0] res_data,
    output logic [31:0]            res_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    typedef enum logic [2:0] {
        IDLE, W_LEN, W_TAP, W_START, STREAM, POLL_RD, POLL_WAIT, DONE
    } state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32'h20);
    localparam logic [31:0]            TAP_LAST  = 32'(Tape_Num - 1);
    localparam logic [31:0]            GAP_LAST  = 32'(POLL_GAP - 1);

    state_t                 r_state;
    logic [31:0]            r_len;
    logic [31:0]            r_in_cnt;
    logic [31:0]            r_out_cnt;
    logic [31:0]            r_tap_i;
    logic [31:0]            r_gap;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic [pADDR_WIDTH-1:0] r_awaddr;
    logic [pDATA_WIDTH-1:0] r_wdata;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_res_valid;
    logic [pDATA_WIDTH-1:0] r_res_data;
    logic [31:0]            r_res_idx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic        w_in_write;
    logic        w_wr_done;
    logic        w_ss_vld;
    logic        w_ss_hs;
    logic        w_sm_rdy;
    logic        w_sm_hs;
    logic [31:0] w_in_nxt;
    logic [31:0] w_out_nxt;

    // A write finishes once each channel has either already handshaken or is handshaking now.
    assign w_in_write = (r_state == W_LEN) || (r_state == W_TAP) || (r_state == W_START);
    assign w_wr_done  = w_in_write && (!r_awvalid || bus.awready) && (!r_wvalid || bus.wready);
    assign w_ss_vld   = (r_state == STREAM) && (r_in_cnt < r_len);
    assign w_ss_hs    = w_ss_vld && bus.ss_tready;
    assign w_sm_rdy   = (r_state == STREAM);
    assign w_sm_hs    = w_sm_rdy && bus.sm_tvalid;
    assign w_in_nxt   = r_in_cnt + 32'(w_ss_hs);
    assign w_out_nxt  = r_out_cnt + 32'(w_sm_hs);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_tap_i     <= '0;
            r_gap       <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (r_awvalid && bus.awready) r_awvalid <= 1'b0;
            if (r_wvalid && bus.wready)   r_wvalid  <= 1'b0;

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_len     <= data_len;
                        r_done    <= 1'b0;
                        r_err     <= 1'b0;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_tap_i   <= '0;
                        if (data_len == 32'd0) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_busy    <= 1'b1;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= ADDR_LEN;
                            r_wdata   <= pDATA_WIDTH'(data_len);
                            r_state   <= W_LEN;
                        end
                    end
                end
                W_LEN: begin
                    if (w_wr_done) begin
                        r_tap_i   <= '0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= ADDR_TAP0;
                        r_state   <= W_TAP;
                    end
                end
                W_TAP: begin
                    if (w_wr_done) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        if (r_tap_i == TAP_LAST) begin
                            r_awaddr <= ADDR_CTRL;
                            r_wdata  <= pDATA_WIDTH'(1);
                            r_state  <= W_START;
                        end else begin
                            r_tap_i  <= r_tap_i + 32'd1;
                            r_awaddr <= r_awaddr + pADDR_WIDTH'(4);
                        end
                    end
                end
                W_START: begin
                    if (w_wr_done) r_state <= STREAM;
                end
                STREAM: begin
                    r_in_cnt  <= w_in_nxt;
                    r_out_cnt <= w_out_nxt;
                    if (w_sm_hs) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= bus.sm_tdata;
                        r_res_idx   <= r_out_cnt;
                        // An early tlast is flagged but the beat is still captured.
                        if (bus.sm_tlast && (r_out_cnt != r_len - 32'd1)) r_err <= 1'b1;
                    end
                    if ((w_in_nxt == r_len) && (w_out_nxt >= r_len)) begin
                        r_arvalid <= 1'b1;
                        r_state   <= POLL_RD;
                    end
                end
                POLL_RD: begin
                    if (r_arvalid && bus.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                    if (r_rready && bus.rvalid) begin
                        r_rready <= 1'b0;
                        if (bus.rdata[1]) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (POLL_GAP == 0) begin
                            r_arvalid <= 1'b1;
                        end else begin
                            r_gap   <= '0;
                            r_state <= POLL_WAIT;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (r_gap == GAP_LAST) begin
                        r_arvalid <= 1'b1;
                        r_state   <= POLL_RD;
                    end else begin
                        r_gap <= r_gap + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Lookup data passes straight through; its index registers keep it stable until the handshake.
    assign bus.awvalid   = r_awvalid;
    assign bus.awaddr    = r_awaddr;
    assign bus.wvalid    = r_wvalid;
    assign bus.wdata     = (r_state == W_TAP) ? tap_val : r_wdata;
    assign bus.arvalid   = r_arvalid;
    assign bus.araddr    = ADDR_CTRL;
    assign bus.rready    = r_rready;
    assign bus.ss_tvalid = w_ss_vld;
    assign bus.ss_tdata  = w_ss_vld ? x_val : '0;
    assign bus.ss_tlast  = w_ss_vld && (r_in_cnt == r_len - 32'd1);
    assign bus.sm_tready = w_sm_rdy;

    assign tap_idx   = r_tap_i[3:0];
    assign x_idx     = r_in_cnt;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_idx   = r_res_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_fir_host_ctrl.sv
// Directed bench for fir_host_ctrl: a behavioural FIR-side slave logs every handshake, then each step checks the logs.
module tb_fir_host_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          start;
    logic [31:0]   data_len;
    logic [3:0]    tap_idx;
    logic [DW-1:0] tap_val;
    logic [31:0]   x_idx;
    logic [DW-1:0] x_val;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [31:0]   res_idx;
    logic          busy, done, err;

    fir_host_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_host_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11), .POLL_GAP(4)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .start      (start),
        .data_len   (data_len),
        .tap_idx    (tap_idx),
        .tap_val    (tap_val),
        .x_idx      (x_idx),
        .x_val      (x_val),
        .bus        (bus),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 axis_clk = ~axis_clk;

    assign tap_val = DW'(tap_idx);
    assign x_val   = x_idx + 32'd1;

    int checks = 0;
    int errors = 0;

    int cyc, wdly, tog, burst, tlast_at, nzero;
    int wcnt, nreads, ss_n, sm_n, last_r_cyc, w_unstable;
    bit w_armed, w_hold, r_pend, ar_prev, have_last_r, any_aw, any_ar, any_ss, tmo;
    logic [31:0] w_prev;
    logic [31:0] aw_q[$], w_q[$], ss_idx_q[$], ss_dat_q[$], res_idx_q[$], res_dat_q[$];
    bit          ss_last_q[$];
    int          gap_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_model();
        wcnt = 0; nreads = 0; ss_n = 0; sm_n = 0; last_r_cyc = 0; w_unstable = 0;
        w_armed = 0; w_hold = 0; r_pend = 0; ar_prev = 0; have_last_r = 0;
        any_aw = 0; any_ar = 0; any_ss = 0;
        aw_q.delete(); w_q.delete(); ss_idx_q.delete(); ss_dat_q.delete();
        ss_last_q.delete(); res_idx_q.delete(); res_dat_q.delete(); gap_q.delete();
    endtask

    // One clock of the FIR-side slave: drive readies/valids at the falling edge, log what handshakes next rise.
    task automatic tick();
        @(negedge axis_clk);
        cyc++;
        bus.awready = 1'b1;
        if (wdly != 0) begin
            if (wcnt > 0) wcnt--;
            bus.wready = (wcnt == 0) && w_armed;
        end else begin
            bus.wready = 1'b1;
        end
        bus.ss_tready = (tog != 0) ? cyc[0] : 1'b1;
        bus.sm_tvalid = (ss_n > sm_n) && ((burst == 0) || ((cyc % 5) < 3));
        bus.sm_tdata  = DW'(32'hA000 + sm_n);
        bus.sm_tlast  = (sm_n == tlast_at);
        bus.arready   = 1'b1;
        bus.rvalid    = r_pend;
        bus.rdata     = (nreads > nzero) ? DW'(2) : DW'(0);

        any_aw |= bus.awvalid;
        any_ar |= bus.arvalid;
        any_ss |= bus.ss_tvalid;
        if (bus.awvalid && bus.awready) begin
            aw_q.push_back(32'(bus.awaddr));
            if (wdly != 0) begin w_armed = 1; wcnt = 3; end
        end
        if (bus.wvalid) begin
            if (w_hold && (bus.wdata !== w_prev)) w_unstable++;
            if (bus.wready) begin
                w_q.push_back(bus.wdata); w_hold = 0; w_armed = 0;
            end else begin
                w_hold = 1; w_prev = bus.wdata;
            end
        end
        if (bus.ss_tvalid && bus.ss_tready) begin
            ss_idx_q.push_back(x_idx); ss_dat_q.push_back(bus.ss_tdata);
            ss_last_q.push_back(bus.ss_tlast); ss_n++;
        end
        if (bus.sm_tvalid && bus.sm_tready) sm_n++;
        if (bus.rvalid && bus.rready) begin r_pend = 0; last_r_cyc = cyc; have_last_r = 1; end
        if (bus.arvalid && !ar_prev && have_last_r) gap_q.push_back(cyc - last_r_cyc - 1);
        ar_prev = bus.arvalid;
        if (bus.arvalid && bus.arready) begin nreads++; r_pend = 1; end
        if (res_valid) begin res_idx_q.push_back(res_idx); res_dat_q.push_back(res_data); end
    endtask

    task automatic launch(input int len);
        clr_model();
        start = 1'b1; data_len = 32'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        tmo = 0;
        while (!done && n < 4000) begin tick(); n++; end
        if (!done) tmo = 1;
    endtask

    task automatic check_writes(input string tag, input int len);
        logic [31:0] ea, ed;
        chk({tag, "_aw_cnt"}, aw_q.size(), 13);
        chk({tag, "_w_cnt"}, w_q.size(), 13);
        for (int i = 0; i < 13; i++) begin
            ea = (i == 0) ? 32'h10 : (i == 12) ? 32'h00 : 32'(32'h20 + 4 * (i - 1));
            ed = (i == 0) ? 32'(len) : (i == 12) ? 32'd1 : 32'(i - 1);
            chk($sformatf("%s_awaddr%0d", tag, i), (i < aw_q.size()) ? aw_q[i] : 32'hDEAD, ea);
            chk($sformatf("%s_wdata%0d", tag, i), (i < w_q.size()) ? w_q[i] : 32'hDEAD, ed);
        end
    endtask

    task automatic check_stream(input string tag, input int len);
        chk({tag, "_ss_cnt"}, ss_idx_q.size(), len);
        chk({tag, "_res_cnt"}, res_idx_q.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < ss_idx_q.size()) begin
                chk($sformatf("%s_x_idx%0d", tag, i), ss_idx_q[i], i);
                chk($sformatf("%s_ss_dat%0d", tag, i), ss_dat_q[i], i + 1);
                chk($sformatf("%s_ss_last%0d", tag, i), ss_last_q[i], (i == len - 1));
            end
            if (i < res_idx_q.size()) begin
                chk($sformatf("%s_res_idx%0d", tag, i), res_idx_q[i], i);
                chk($sformatf("%s_res_dat%0d", tag, i), res_dat_q[i], 32'hA000 + i);
            end
        end
    endtask

    initial begin
        axis_rst_n = 1'b1; start = 1'b0; data_len = '0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0; bus.rvalid = 0; bus.rdata = '0;
        bus.ss_tready = 0; bus.sm_tvalid = 0; bus.sm_tdata = '0; bus.sm_tlast = 0;
        cyc = 0; wdly = 0; tog = 0; burst = 0; tlast_at = -1; nzero = 0;
        clr_model();
        #2 axis_rst_n = 1'b0;
        tick(); tick();
        chk("rst_ctrl", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, bus.ss_tvalid,
                         bus.sm_tready, bus.ss_tlast, res_valid, busy, done, err}, 0);
        chk("rst_data", |{bus.awaddr, bus.wdata, bus.ss_tdata, tap_idx, x_idx, res_idx, res_data}, 0);
        #1 axis_rst_n = 1'b1;
        tick();

        // len = 0: immediate error completion, no bus traffic
        launch(0);
        chk("len0_done", done, 1);
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("len0_no_traffic", {any_aw, any_ar, any_ss}, 0);

        // Basic run, slave always ready
        tlast_at = 4;
        launch(5);
        chk("t1_busy", busy, 1);
        chk("t1_done_clr", {done, err}, 0);
        wait_done();
        chk("t1_timeout", tmo, 0);
        check_writes("t1", 5);
        check_stream("t1", 5);
        chk("t1_flags", {busy, done, err}, 3'b010);
        chk("t1_reads", nreads, 1);

        // wready lags awready by 3 cycles
        wdly = 1; tlast_at = 2;
        launch(3);
        wait_done();
        chk("t2_timeout", tmo, 0);
        check_writes("t2", 3);
        chk("t2_wdata_stable", w_unstable, 0);
        chk("t2_flags", {busy, done, err}, 3'b010);

        // Toggling ss_tready, bursty sm_tvalid, and an ignored start while busy
        wdly = 0; tog = 1; burst = 1; tlast_at = 6;
        launch(7);
        tick(); tick(); tick();
        start = 1'b1; data_len = 32'd0;
        tick();
        start = 1'b0;
        chk("t3_start_ignored", {busy, err}, 2'b10);
        wait_done();
        chk("t3_timeout", tmo, 0);
        check_stream("t3", 7);
        chk("t3_flags", {busy, done, err}, 3'b010);

        // Status not done for three reads
        tog = 0; burst = 0; nzero = 3; tlast_at = 1;
        launch(2);
        wait_done();
        chk("t4_timeout", tmo, 0);
        chk("t4_reads", nreads, 4);
        chk("t4_gap_cnt", gap_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t4_gap%0d", i), (i < gap_q.size()) ? gap_q[i] : -1, 4);
        chk("t4_flags", {busy, done, err}, 3'b010);

        // Early sm_tlast on output 2
        nzero = 0; tlast_at = 2;
        launch(5);
        wait_done();
        chk("t5_timeout", tmo, 0);
        chk("t5_res_cnt", res_idx_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t5_res_idx%0d", i), (i < res_idx_q.size()) ? res_idx_q[i] : 32'hDEAD, i);
        chk("t5_flags", {busy, done, err}, 3'b011);

        // Reset in the middle of STREAM, then a clean rerun
        tlast_at = 5;
        launch(6);
        for (int n = 0; n < 500 && ss_n < 2; n++) tick();
        chk("t6_in_stream", ss_n >= 2, 1);
        #1 axis_rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, bus.ss_tvalid,
                            bus.sm_tready, bus.ss_tlast, res_valid, busy, done, err}, 0);
        chk("t6_rst_data", |{bus.awaddr, bus.wdata, bus.ss_tdata, tap_idx, x_idx, res_idx, res_data}, 0);
        tick(); tick();
        #1 axis_rst_n = 1'b1;
        tick();
        tlast_at = 3;
        launch(4);
        wait_done();
        chk("t7_timeout", tmo, 0);
        check_writes("t7", 4);
        check_stream("t7", 4);
        chk("t7_flags", {busy, done, err}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
